address_path_checker: RTL and testbench

//  Synthesizable monitor downstream of the 6502 core's address bus.

---
 rtl/apc_pkg.sv | 15 +
 rtl/apc_path_ram.sv | 27 ++
 rtl/address_path_checker.sv | 142 ++++++++++++++
 tb/tb_address_path_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apc_pkg.sv
// Shared types and default sizing for the address path checker.
package apc_pkg;

    localparam int APC_ADDR_W     = 16;
    localparam int APC_IDX_W      = 12;
    localparam int APC_MAX_MISSES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } apc_state_t;

endpackage

// File: rtl/apc_path_ram.sv
// Expected-address table: one synchronous write port, one combinational read port.
// The combinational read lets consecutive steps match on back-to-back edges.
module apc_path_ram
    import apc_pkg::*;
#(
    parameter int ADDR_W = APC_ADDR_W,
    parameter int IDX_W  = APC_IDX_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_data
);

    logic [ADDR_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/address_path_checker.sv
// Walks a table of expected CPU addresses and reports pass, or failure after too
// many consecutive misses.
module address_path_checker
    import apc_pkg::*;
#(
    parameter int ADDR_W     = APC_ADDR_W,
    parameter int IDX_W      = APC_IDX_W,
    parameter int MAX_MISSES = APC_MAX_MISSES
) (
    input  logic              ph2,
    input  logic              resetb,
    input  logic [ADDR_W-1:0] address,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [ADDR_W-1:0] load_data,
    input  logic [IDX_W:0]    path_len,
    input  logic              start,
    input  logic              clear,
    output logic [IDX_W:0]    step_idx,
    output logic [7:0]        misses,
    output logic              match,
    output logic              pass,
    output logic              fail,
    output logic [IDX_W:0]    fail_idx,
    output logic              busy
);

    apc_state_t        state_reg, state_next;
    logic [IDX_W:0]    len_reg;
    logic [IDX_W:0]    step_reg;
    logic [IDX_W:0]    fail_idx_reg;
    logic [7:0]        miss_reg;
    logic              match_reg;
    logic [ADDR_W-1:0] expected;
    logic [IDX_W:0]    step_inc;
    logic              table_wr;
    logic              hit;
    logic              last_hit;
    logic              miss_limit;

    assign table_wr = (state_reg == IDLE) && load_en;

    // step_reg only reaches 2**IDX_W once the path is complete, so the low bits always address a valid entry.
    apc_path_ram #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_path_ram (
        .clk     (ph2),
        .wr_en   (table_wr),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_idx  (step_reg[IDX_W-1:0]),
        .rd_data (expected)
    );

    assign step_inc   = step_reg + 1'b1;
    assign hit        = (address == expected);
    assign last_hit   = (step_inc == len_reg);
    assign miss_limit = (miss_reg == 8'(MAX_MISSES));

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = (path_len == '0) ? PASS : RUN;
                    end
                end
                RUN: begin
                    if (hit) begin
                        if (last_hit) begin
                            state_next = PASS;
                        end
                    end else if (miss_limit) begin
                        state_next = FAIL;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // Clear leaves step/miss counters untouched so an aborted run can be inspected.
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            len_reg      <= '0;
            step_reg     <= '0;
            fail_idx_reg <= '0;
            miss_reg     <= '0;
            match_reg    <= 1'b0;
        end else begin
            match_reg <= 1'b0;
            if (!clear) begin
                if ((state_reg == IDLE) && start) begin
                    len_reg      <= path_len;
                    step_reg     <= '0;
                    miss_reg     <= '0;
                    fail_idx_reg <= '0;
                end else if (state_reg == RUN) begin
                    if (hit) begin
                        match_reg <= 1'b1;
                        miss_reg  <= '0;
                        step_reg  <= step_inc;
                    end else begin
                        miss_reg     <= miss_reg + 1'b1;
                        fail_idx_reg <= step_reg;
                    end
                end
            end
        end
    end

    always_comb begin
        busy     = 1'b0;
        pass     = 1'b0;
        fail     = 1'b0;
        step_idx = step_reg;
        misses   = miss_reg;
        match    = match_reg;
        fail_idx = fail_idx_reg;
        case (state_reg)
            RUN:     busy = 1'b1;
            PASS:    pass = 1'b1;
            FAIL:    fail = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_address_path_checker.sv
// Directed bench for address_path_checker: a behavioural model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_address_path_checker;

    localparam int ADDR_W = 16;
    localparam int IDX_W  = 12;
    localparam int MAXM   = 15;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;

    logic              ph2 = 1'b0;
    logic              resetb = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              load_en = 1'b0;
    logic [IDX_W-1:0]  load_idx = '0;
    logic [ADDR_W-1:0] load_data = '0;
    logic [IDX_W:0]    path_len = '0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic [IDX_W:0]    step_idx;
    logic [7:0]        misses;
    logic              match;
    logic              pass;
    logic              fail;
    logic [IDX_W:0]    fail_idx;
    logic              busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [ADDR_W-1:0] m_tab [4096];
    int m_mode  = M_IDLE;
    int m_step  = 0;
    int m_miss  = 0;
    int m_fidx  = 0;
    int m_len   = 0;
    int m_match = 0;

    address_path_checker #(
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .MAX_MISSES (MAXM)
    ) dut (
        .ph2       (ph2),
        .resetb    (resetb),
        .address   (address),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data),
        .path_len  (path_len),
        .start     (start),
        .clear     (clear),
        .step_idx  (step_idx),
        .misses    (misses),
        .match     (match),
        .pass      (pass),
        .fail      (fail),
        .fail_idx  (fail_idx),
        .busy      (busy)
    );

    always #5 ph2 = ~ph2;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            m_mode = M_IDLE; m_step = 0; m_miss = 0; m_fidx = 0; m_len = 0; m_match = 0;
        end else begin
            m_match = 0;
            if (clear) begin
                m_mode = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (load_en) m_tab[load_idx] = load_data;
                if (start) begin
                    m_len = int'(path_len); m_step = 0; m_miss = 0; m_fidx = 0;
                    m_mode = (m_len == 0) ? M_PASS : M_RUN;
                end
            end else if (m_mode == M_RUN) begin
                if (address == m_tab[m_step]) begin
                    m_match = 1; m_miss = 0; m_step = m_step + 1;
                    if (m_step == m_len) m_mode = M_PASS;
                end else begin
                    m_fidx = m_step; m_miss = m_miss + 1;
                    if (m_miss > MAXM) m_mode = M_FAIL;
                end
            end
        end
    end

    always @(negedge ph2) begin
        if (chk_en) begin
            cmp("model_step_idx", int'(step_idx), m_step);
            cmp("model_misses", int'(misses), m_miss);
            cmp("model_match", int'(match), m_match);
            cmp("model_pass", int'(pass), int'(m_mode == M_PASS));
            cmp("model_fail", int'(fail), int'(m_mode == M_FAIL));
            cmp("model_busy", int'(busy), int'(m_mode == M_RUN));
            cmp("model_fail_idx", int'(fail_idx), m_fidx);
        end
    end

    task automatic cyc();
        @(negedge ph2);
    endtask

    task automatic load(input int idx, input int data);
        load_en = 1'b1; load_idx = IDX_W'(idx); load_data = ADDR_W'(data);
        cyc();
        load_en = 1'b0;
    endtask

    task automatic go(input int len);
        path_len = (IDX_W+1)'(len); start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic drive(input int a);
        address = ADDR_W'(a);
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge ph2);
        resetb = 1'b1;
        chk_en = 1'b1;
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_step", int'(step_idx), 0);
        cmp("rst_pass", int'(pass), 0);

        // 1: clean three-step path
        load(0, 'hFFFC); load(1, 'hFFFD); load(2, 'hFA62);
        go(3);
        cmp("t1_busy", int'(busy), 1);
        drive('hFFFC);
        cmp("t1_match1", int'(match), 1);
        cmp("t1_step1", int'(step_idx), 1);
        drive('hFFFD);
        cmp("t1_match2", int'(match), 1);
        drive('hFA62);
        cmp("t1_match3", int'(match), 1);
        cmp("t1_pass", int'(pass), 1);
        cmp("t1_misses", int'(misses), 0);
        cmp("t1_step3", int'(step_idx), 3);

        // 2: five misses in the middle
        do_clear();
        cmp("t2_clr_pass", int'(pass), 0);
        go(3);
        drive('hFFFC);
        repeat (5) drive('h1234);
        cmp("t2_misses5", int'(misses), 5);
        cmp("t2_fidx", int'(fail_idx), 1);
        drive('hFFFD);
        cmp("t2_miss_rst", int'(misses), 0);
        cmp("t2_match", int'(match), 1);
        drive('hFA62);
        cmp("t2_pass", int'(pass), 1);

        // 3: sixteen misses fail
        do_clear();
        go(3);
        drive('hFFFC);
        repeat (15) drive('h0001);
        cmp("t3_misses15", int'(misses), 15);
        cmp("t3_busy15", int'(busy), 1);
        cmp("t3_fail15", int'(fail), 0);
        drive('h0001);
        cmp("t3_fail", int'(fail), 1);
        cmp("t3_fidx", int'(fail_idx), 1);
        cmp("t3_misses16", int'(misses), 16);
        cmp("t3_pass", int'(pass), 0);
        drive('hFFFD);
        cmp("t3_sticky", int'(fail), 1);

        // 6: clear from FAIL keeps counters; clear beats start
        do_clear();
        cmp("t6_busy", int'(busy), 0);
        cmp("t6_fail", int'(fail), 0);
        cmp("t6_step_kept", int'(step_idx), 1);
        cmp("t6_miss_kept", int'(misses), 16);
        clear = 1'b1; start = 1'b1; path_len = 3;
        cyc();
        clear = 1'b0; start = 1'b0;
        cmp("t6_clr_wins", int'(busy), 0);
        cyc();
        cmp("t6_still_idle", int'(busy), 0);

        // 4: empty path passes at once; load_en ignored while running
        go(0);
        cmp("t4_pass0", int'(pass), 1);
        cmp("t4_step0", int'(step_idx), 0);
        do_clear();
        go(3);
        load_en = 1'b1; load_idx = 1; load_data = 'hBEEF; address = 'hFFFC;
        cyc();
        load_en = 1'b0;
        cmp("t4_match1", int'(match), 1);
        drive('hFFFD);
        cmp("t4_tab_kept", int'(match), 1);
        drive('hFA62);
        cmp("t4_pass", int'(pass), 1);

        // 5: asynchronous reset mid-run, then replay
        do_clear();
        go(3);
        drive('hFFFC);
        drive('hFFFD);
        drive('h5555);
        cmp("t5_pre_fidx", int'(fail_idx), 2);
        #2 resetb = 1'b0;
        #1;
        cmp("t5_rst_step", int'(step_idx), 0);
        cmp("t5_rst_miss", int'(misses), 0);
        cmp("t5_rst_fidx", int'(fail_idx), 0);
        cmp("t5_rst_busy", int'(busy), 0);
        cmp("t5_rst_flags", int'({match, pass, fail}), 0);
        @(negedge ph2);
        resetb = 1'b1;
        go(3);
        drive('hFFFC);
        drive('hFFFD);
        drive('hFA62);
        cmp("t5_replay_pass", int'(pass), 1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
